// File: rtl/banked_ram_pkg.sv
// Shared types and helpers for the banked byte RAM.
// Lane mapping and range check used by both ports.
package banked_ram_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  function automatic int lane_of(int bank, int r, int n);
    return (bank - r + n) % n;
  endfunction

  function automatic logic in_range(logic [63:0] addr, int n, int ws);
    return (addr + 64'(n) - 64'd1) < (64'(n) * 64'(ws));
  endfunction

endpackage

// File: rtl/bank_addr_split.sv
// Byte address to row/bank-offset split by a constant bank count.
// Reciprocal multiply underestimates by at most one; one fix-up step.
module bank_addr_split #(
  parameter int BANK_NUM = 4,
  parameter int AW       = 32,
  parameter int RBW      = 2
) (
  input  logic [AW-1:0]  addr,
  output logic [AW-1:0]  q,
  output logic [RBW-1:0] r
);

  localparam logic [AW:0] RECIP =
    {1'b1, {AW{1'b0}}} / (AW+1)'(BANK_NUM);

  logic [2*AW+1:0] prod;
  logic [AW-1:0]   q_est;
  logic [AW-1:0]   r_est;
  logic [AW-1:0]   r_full;
  logic            fix;
  logic            unused_bits;

  assign prod  = (2*AW+2)'(addr) * (2*AW+2)'(RECIP);
  assign q_est = prod[2*AW-1:AW];
  assign r_est = addr - q_est * AW'(BANK_NUM);
  assign fix   = r_est >= AW'(BANK_NUM);

  assign q      = fix ? q_est + AW'(1) : q_est;
  assign r_full = fix ? r_est - AW'(BANK_NUM) : r_est;
  assign r      = r_full[RBW-1:0];

  assign unused_bits = ^{prod[2*AW+1:2*AW], prod[AW-1:0],
                         r_full[AW-1:RBW]};

endmodule

// File: rtl/banked_unaligned_ram.sv
// Byte-banked 1W/1R RAM taking full words at any byte address.
// Clears on reset or request; forwards same-cycle writes to reads.
module banked_unaligned_ram
  import banked_ram_pkg::*;
#(
  parameter int          BANK_NUM      = 4,
  parameter int          WORD_SIZE     = 1024,
  parameter int          ADDRESS_WIDTH = 32,
  parameter logic [7:0]  CLEAR_VALUE   = 8'h00
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_wvalid,
  output logic                     o_wready,
  input  logic [BANK_NUM-1:0]      i_wstrb,
  input  logic [ADDRESS_WIDTH-1:0] i_waddr,
  input  logic [8*BANK_NUM-1:0]    i_wdata,
  input  logic                     i_rvalid,
  output logic                     o_rready,
  input  logic [ADDRESS_WIDTH-1:0] i_raddr,
  output logic                     o_rvalid,
  output logic [8*BANK_NUM-1:0]    o_rdata,
  output logic                     o_rerr
);

  localparam int AW  = ADDRESS_WIDTH;
  localparam int DW  = 8 * BANK_NUM;
  localparam int RW  = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam int RBW = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

  state_t         state, state_nxt;
  logic [RW-1:0]  cnt, cnt_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      CLEAR: begin
        if (i_clr) begin
          cnt_nxt = '0;
        end else if (cnt == RW'(WORD_SIZE - 1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + RW'(1);
        end
      end
      RUN: begin
        if (i_clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  logic clearing, racc, wok, rok;

  assign clearing = state == CLEAR;
  assign o_wready = state == RUN;
  assign o_rready = state == RUN;
  assign racc     = i_rvalid && o_rready;
  assign wok      = i_wvalid && o_wready &&
                    in_range(64'(i_waddr), BANK_NUM, WORD_SIZE);
  assign rok      = in_range(64'(i_raddr), BANK_NUM, WORD_SIZE);

  logic [AW-1:0]  wq, rq;
  logic [RBW-1:0] wr, rr;

  bank_addr_split #(.BANK_NUM(BANK_NUM), .AW(AW), .RBW(RBW)) u_wsplit (
    .addr (i_waddr),
    .q    (wq),
    .r    (wr)
  );

  bank_addr_split #(.BANK_NUM(BANK_NUM), .AW(AW), .RBW(RBW)) u_rsplit (
    .addr (i_raddr),
    .q    (rq),
    .r    (rr)
  );

  logic [RW-1:0] wrow_lo, wrow_hi, rrow_lo, rrow_hi;
  logic          unused_bits;

  assign wrow_lo     = wq[RW-1:0];
  assign wrow_hi     = wrow_lo + RW'(1);
  assign rrow_lo     = rq[RW-1:0];
  assign rrow_hi     = rrow_lo + RW'(1);
  assign unused_bits = ^{wq[AW-1:RW], rq[AW-1:RW]};

  logic [DW-1:0] bank_flat;

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    logic [7:0]    mem [WORD_SIZE];
    logic [7:0]    wbyte, q;
    logic          wen;
    logic [RW-1:0] wrow, rrow;

    assign wrow = (RBW'(b) < wr) ? wrow_hi : wrow_lo;
    assign rrow = (RBW'(b) < rr) ? rrow_hi : rrow_lo;

    always_comb begin
      wbyte = '0;
      wen   = 1'b0;
      for (int l = 0; l < BANK_NUM; l++) begin
        if (lane_of(b, int'(wr), BANK_NUM) == l) begin
          wbyte = i_wdata[l*8 +: 8];
          wen   = i_wstrb[l];
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (clearing)
        mem[cnt] <= CLEAR_VALUE;
      else if (wok && wen)
        mem[wrow] <= wbyte;
    end

    // same bank and row means same byte address: bypass the array
    always_ff @(posedge i_clk) begin
      if (i_rst)
        q <= '0;
      else if (racc)
        q <= (wok && wen && wrow == rrow) ? wbyte : mem[rrow];
    end

    assign bank_flat[b*8 +: 8] = q;
  end

  logic [RBW-1:0] r_q;
  logic           err_q, rvalid_q;
  logic [DW-1:0]  rot;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q      <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= racc;
      if (racc) begin
        r_q   <= rr;
        err_q <= !rok;
      end
    end
  end

  always_comb begin
    rot = '0;
    for (int l = 0; l < BANK_NUM; l++) begin
      for (int b = 0; b < BANK_NUM; b++) begin
        if (lane_of(b, int'(r_q), BANK_NUM) == l)
          rot[l*8 +: 8] = bank_flat[b*8 +: 8];
      end
    end
  end

  assign o_rvalid = rvalid_q;
  assign o_rerr   = err_q;
  assign o_rdata  = err_q ? '0 : rot;

endmodule
